// File: rtl/demux_2_buf.sv
// demux_2_buf: registered 1-to-2 demultiplexer with a one-word holding register,
// valid/ready handshake and a wrapping delivered-word counter on each output channel.
`default_nettype none

module demux_2_buf #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic space0;
  logic space1;
  logic accept0;
  logic accept1;
  logic deliver0;
  logic deliver1;

  // A channel can take a word if it is empty or is being drained this same cycle.
  always_comb begin
    space0   = !out0_valid | out0_ready;
    space1   = !out1_valid | out1_ready;
    in_ready = in_sel ? space1 : space0;
    accept0  = in_valid & !in_sel & space0;
    accept1  = in_valid &  in_sel & space1;
    deliver0 = out0_valid & out0_ready;
    deliver1 = out1_valid & out1_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out0_data  <= '0;
      out0_valid <= 1'b0;
      cnt0       <= '0;
    end else begin
      if (accept0) begin
        out0_data  <= in_data;
        out0_valid <= 1'b1;
      end else if (deliver0) begin
        out0_valid <= 1'b0;
      end
      if (deliver0) begin
        cnt0 <= cnt0 + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out1_data  <= '0;
      out1_valid <= 1'b0;
      cnt1       <= '0;
    end else begin
      if (accept1) begin
        out1_data  <= in_data;
        out1_valid <= 1'b1;
      end else if (deliver1) begin
        out1_valid <= 1'b0;
      end
      if (deliver1) begin
        cnt1 <= cnt1 + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_demux_2_buf.sv
// tb_demux_2_buf: directed self-checking bench for demux_2_buf.
`default_nettype none

module tb_demux_2_buf;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int passed = 0;
  int total  = 0;

  demux_2_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    step();
    step();
    check("rst_v0",    out0_valid, 0);
    check("rst_v1",    out1_valid, 0);
    check("rst_d0",    out0_data, 0);
    check("rst_d1",    out1_data, 0);
    check("rst_c0",    cnt0, 0);
    check("rst_c1",    cnt1, 0);
    check("rst_ready", in_ready, 1);
    reset = 1'b0;

    // in_valid low: bus contents ignored
    in_data = 4'h7;
    step();
    check("idle_v0", out0_valid, 0);
    check("idle_d0", out0_data, 0);

    // Load channel 0 with 1010, consumer stalled
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'b1010;
    #1 check("t1_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t1_v0", out0_valid, 1);
    check("t1_d0", out0_data, 4'b1010);
    check("t1_v1", out1_valid, 0);
    check("t1_c0", cnt0, 0);

    // Channel 0 full: its words are blocked, channel 1 still accepts
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'b0101;
    #1 check("t2_ready_blk", in_ready, 0);
    step();
    check("t2_d0_hold", out0_data, 4'b1010);
    check("t2_v0_hold", out0_valid, 1);
    in_sel = 1'b1;
    #1 check("t2_ready_ch1", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("t2_v1", out1_valid, 1);
    check("t2_d1", out1_data, 4'b0101);
    check("t2_d0", out0_data, 4'b1010);

    // Simultaneous delivery and refill on channel 0
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 4'b1100;
    #1 check("t3_ready", in_ready, 1);
    step();
    in_valid = 1'b0; out0_ready = 1'b0;
    check("t3_v0", out0_valid, 1);
    check("t3_d0", out0_data, 4'b1100);
    check("t3_c0", cnt0, 1);
    check("t3_c1", cnt1, 0);

    // Asynchronous reset pulse between clock edges
    reset = 1'b1;
    #2;
    check("arst_v0", out0_valid, 0);
    check("arst_v1", out1_valid, 0);
    reset = 1'b0;
    step();

    // Park 1111 in stalled channel 0, then stream on channel 1
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hF;
    step();
    check("t4_v0", out0_valid, 1);
    out1_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_sel = 1'b1; in_data = WIDTH'(i);
      #1 check("t4_ready", in_ready, 1);
      step();
      check("t4_d1", out1_data, i);
      check("t4_v1", out1_valid, 1);
    end
    in_valid = 1'b0;
    check("t4_c1_mid", cnt1, 3);
    step();
    check("t4_c1", cnt1, 4);
    check("t4_v1_end", out1_valid, 0);
    check("t4_d1_end", out1_data, 4'b0100);
    check("t4_d0", out0_data, 4'hF);
    check("t4_c0", cnt0, 0);
    out1_ready = 1'b0;

    // 256 deliveries on channel 0 wrap the counter
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      in_data = WIDTH'(i);
      step();
      if (i == 254) check("t5_c0_255", cnt0, 255);
    end
    check("t5_c0_wrap", cnt0, 0);
    check("t5_v0", out0_valid, 1);
    check("t5_d0", out0_data, 4'hF);
    in_valid = 1'b0;
    step();
    check("t5_c0_one", cnt0, 1);
    check("t5_v0_end", out0_valid, 0);

    // Bring cnt0 to 3 with channel 0 holding 1111, channel 1 holding 0101
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h3;
    step();
    in_data = 4'h6;
    step();
    in_data = 4'hF;
    step();
    out0_ready = 1'b0;
    in_sel = 1'b1; in_data = 4'b0101;
    step();
    check("t6_c0", cnt0, 3);
    check("t6_d0", out0_data, 4'hF);
    check("t6_d1", out1_data, 4'b0101);
    check("t6_v1", out1_valid, 1);

    // Reset with both channels full and a word still offered
    in_sel = 1'b0; in_data = 4'h9;
    reset = 1'b1;
    #1;
    check("t6_v0", out0_valid, 0);
    check("t6_v1_rst", out1_valid, 0);
    check("t6_d0_rst", out0_data, 0);
    check("t6_d1_rst", out1_data, 0);
    check("t6_c0_rst", cnt0, 0);
    check("t6_c1_rst", cnt1, 0);
    check("t6_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    reset = 1'b0;
    step();
    check("t6_discard", out0_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
